// File: rtl/spi_flash_read.sv
// SPI NOR flash sequential reader. Each read does a die select (C2 xx), then a read
// command with a 4-byte address (optional 8 dummy clocks), then streams bytes until the
// last address. At a 32 MB die boundary it reselects the die and reissues the command.
module spi_flash_read (
  input  logic        system_clk,
  input  logic        system_reset_n,  // active-high synchronous reset
  input  logic        start_flag,
  input  logic        read_req,
  input  logic [31:0] start_addr,
  input  logic [31:0] end_addr,
  input  logic [1:0]  mode,
  input  logic        fifo_full,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        read_finish
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DIE_SEL = 4'd1,
    CMD     = 4'd2,
    ADDR    = 4'd3,
    DUMMY   = 4'd4,
    DATA    = 4'd5,
    PAUSE   = 4'd6,
    CS_GAP  = 4'd7,
    FINISH  = 4'd8
  } state_e;

  state_e      state, next_state;
  logic        start_flag_q;
  logic [31:0] cur_addr_q, remaining_q;
  logic [1:0]  mode_q;
  logic [6:0]  tx_q;         // bits of the current byte still to be shifted out
  logic [7:0]  rx_q;
  logic [2:0]  bit_q, gap_q;
  logic [1:0]  byte_q;       // byte index within a multi-byte state
  logic        die_pend_q;   // CS_GAP must go back to DIE_SEL (die crossing)
  logic        pause_req_q;  // fifo_full seen during the byte in flight
  logic        sw;           // one-cycle die-switch marker

  logic        start_evt, shifting, byte_done, last_byte, die_cross, pause_now, load_en;
  logic [7:0]  load_byte, opcode;

  assign start_evt = (start_flag & ~start_flag_q) | read_req;
  assign shifting  = state inside {DIE_SEL, CMD, ADDR, DUMMY, DATA};
  // sclk high in a shifting state means this edge is the falling edge
  assign byte_done = shifting & spi_sclk & (bit_q == 3'd7);
  assign last_byte = (remaining_q == 32'd1);
  assign die_cross = &cur_addr_q[24:0];
  assign pause_now = fifo_full | pause_req_q;
  assign opcode    = (mode_q == 2'b01) ? 8'h0C : 8'h13;

  // Next-state decode; transitions out of shifting states only at byte boundaries.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start_evt) next_state = (end_addr < start_addr) ? FINISH : DIE_SEL;
      DIE_SEL: if (byte_done && byte_q == 2'd1) next_state = CS_GAP;
      CS_GAP:  if (gap_q == 3'd3) next_state = die_pend_q ? DIE_SEL : CMD;
      CMD:     if (byte_done) next_state = ADDR;
      ADDR: begin
        if (byte_done && byte_q == 2'd3) begin
          if (mode_q == 2'b01) next_state = DUMMY;
          else                 next_state = pause_now ? PAUSE : DATA;
        end
      end
      DUMMY:   if (byte_done) next_state = pause_now ? PAUSE : DATA;
      DATA: begin
        if (byte_done) begin
          if (last_byte)      next_state = FINISH;
          else if (die_cross) next_state = CS_GAP;
          else if (pause_now) next_state = PAUSE;
          else                next_state = DATA;
        end
      end
      PAUSE:   if (!fifo_full) next_state = DATA;
      FINISH:  if (!start_flag && !read_req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Byte to place on MOSI at the start of the next byte slot.
  always_comb begin
    load_en   = 1'b0;
    load_byte = 8'h00;
    unique case (state)
      IDLE, CS_GAP: begin
        if (next_state == DIE_SEL) begin
          load_en   = 1'b1;
          load_byte = 8'hC2;
        end else if (next_state == CMD) begin
          load_en   = 1'b1;
          load_byte = opcode;
        end
      end
      DIE_SEL: begin
        if (byte_done && byte_q == 2'd0) begin
          load_en   = 1'b1;
          load_byte = {7'b0, cur_addr_q[25]};
        end
      end
      CMD: begin
        if (byte_done) begin
          load_en   = 1'b1;
          load_byte = cur_addr_q[31:24];
        end
      end
      ADDR: begin
        if (byte_done) begin
          load_en = 1'b1;
          case (byte_q)
            2'd0:    load_byte = cur_addr_q[23:16];
            2'd1:    load_byte = cur_addr_q[15:8];
            2'd2:    load_byte = cur_addr_q[7:0];
            default: load_byte = 8'h00;
          endcase
        end
      end
      default: ;
    endcase
  end

  // State register, serial engine and registered outputs.
  always_ff @(posedge system_clk) begin
    if (system_reset_n) begin
      state        <= IDLE;
      start_flag_q <= 1'b0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      mode_q       <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      byte_q       <= '0;
      die_pend_q   <= 1'b0;
      pause_req_q  <= 1'b0;
      sw           <= 1'b0;
      spi_cs_n     <= 1'b1;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      read_finish  <= 1'b0;
    end else begin
      state        <= next_state;
      start_flag_q <= start_flag;
      data_valid   <= 1'b0;
      gap_q        <= (state == CS_GAP) ? gap_q + 3'd1 : 3'd0;
      pause_req_q  <= (state == DATA) && !byte_done && (pause_req_q || fifo_full);
      sw           <= (state == DATA) && byte_done && !last_byte && die_cross;
      spi_cs_n     <= !(next_state inside {DIE_SEL, CMD, ADDR, DUMMY, DATA, PAUSE});
      read_finish  <= (next_state == FINISH);

      // Mode 0: sample MISO on the rising edge, advance MOSI on the falling edge.
      if (shifting) begin
        spi_sclk <= ~spi_sclk;
        if (!spi_sclk) begin
          rx_q <= {rx_q[6:0], spi_miso};
        end else begin
          bit_q    <= bit_q + 3'd1;
          spi_mosi <= tx_q[6];
          tx_q     <= {tx_q[5:0], 1'b0};
          if (bit_q == 3'd7) byte_q <= byte_q + 2'd1;
        end
      end
      if (next_state != state) byte_q <= '0;
      if (load_en) begin
        spi_mosi <= load_byte[7];
        tx_q     <= load_byte[6:0];
      end

      if (state == IDLE && start_evt) begin
        cur_addr_q  <= start_addr;
        remaining_q <= end_addr - start_addr + 32'd1;
        mode_q      <= mode;
      end
      if (state == DATA && byte_done) begin
        data_out    <= rx_q;
        data_valid  <= 1'b1;
        cur_addr_q  <= cur_addr_q + 32'd1;
        remaining_q <= remaining_q - 32'd1;
      end
      if (state == DATA && next_state == CS_GAP) die_pend_q <= 1'b1;
      else if (state == CS_GAP && next_state == DIE_SEL) die_pend_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_flash_read.sv
// Directed bench for spi_flash_read with a behavioural SPI flash that decodes the
// command/address from MOSI and returns fdata(address) on MISO.
module tb_spi_flash_read;

  logic        system_clk = 1'b0;
  logic        system_reset_n = 1'b1;
  logic        start_flag = 1'b0;
  logic        read_req = 1'b0;
  logic [31:0] start_addr = '0;
  logic [31:0] end_addr = '0;
  logic [1:0]  mode = '0;
  logic        fifo_full = 1'b0;
  logic        spi_miso = 1'b0;
  logic        spi_cs_n, spi_sclk, spi_mosi, data_valid, read_finish;
  logic [7:0]  data_out;

  always #5 system_clk = ~system_clk;

  spi_flash_read dut (
    .system_clk     (system_clk),
    .system_reset_n (system_reset_n),
    .start_flag     (start_flag),
    .read_req       (read_req),
    .start_addr     (start_addr),
    .end_addr       (end_addr),
    .mode           (mode),
    .fifo_full      (fifo_full),
    .spi_miso       (spi_miso),
    .spi_cs_n       (spi_cs_n),
    .spi_sclk       (spi_sclk),
    .spi_mosi       (spi_mosi),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .read_finish    (read_finish)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] fdata(input logic [31:0] a);
    fdata = a[7:0] ^ {a[25], a[14:8]} ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash model and monitors, all sampled on the falling system clock edge.
  logic [7:0]  rxb[$];
  logic [7:0]  win_b[32][8];
  int          win_nb[32];
  int          win_clk[32];
  int          win_cnt = 0, cur_w = 0, bitcnt = 0, hdr = 1000, idx = 0;
  int          sw_cnt = 0, stall_cnt = 0, gap_run = 0, min_gap = 1000;
  logic [7:0]  sh = '0, fd = '0;
  logic [31:0] faddr = '0;
  logic        cs_prev = 1'b1, sclk_prev = 1'b0;

  always @(negedge system_clk) begin
    if (data_valid) rxb.push_back(data_out);
    if (dut.sw) sw_cnt++;
    if (!spi_cs_n && !cs_prev && !spi_sclk && !sclk_prev) stall_cnt++;
    if (spi_cs_n) gap_run++;
    if (!spi_cs_n && cs_prev) begin
      if (gap_run < min_gap) min_gap = gap_run;
      gap_run = 0;
      cur_w   = win_cnt;
      win_cnt++;
      bitcnt  = 0;
      hdr     = 1000;
      if (cur_w < 32) begin
        win_nb[cur_w]  = 0;
        win_clk[cur_w] = 0;
      end
    end
    if (!spi_cs_n && spi_sclk && !sclk_prev) begin
      sh = {sh[6:0], spi_mosi};
      bitcnt++;
      if (cur_w < 32) win_clk[cur_w]++;
      if (bitcnt > 8 && bitcnt <= 40) faddr = {faddr[30:0], spi_mosi};
      if (bitcnt % 8 == 0 && cur_w < 32) begin
        if (win_nb[cur_w] < 8) win_b[cur_w][win_nb[cur_w]] = sh;
        win_nb[cur_w]++;
      end
      if (bitcnt == 8) hdr = (sh == 8'h0C) ? 48 : (sh == 8'h13) ? 40 : 1000;
    end
    if (!spi_cs_n && !spi_sclk && sclk_prev && bitcnt >= hdr) begin
      idx      = bitcnt - hdr;
      fd       = fdata(faddr + 32'(idx / 8));
      spi_miso = fd[7 - (idx % 8)];
    end
    cs_prev   = spi_cs_n;
    sclk_prev = spi_sclk;
  end

  task automatic do_read(input logic [31:0] sa, input logic [31:0] ea, input logic [1:0] md,
                         input bit use_req);
    @(negedge system_clk);
    start_addr = sa;
    end_addr   = ea;
    mode       = md;
    if (use_req) read_req = 1'b1;
    else         start_flag = 1'b1;
    @(negedge system_clk);
    read_req = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    int n = 0;
    while (!read_finish && n < 4000) begin
      @(negedge system_clk);
      n++;
    end
    check({tag, "_finish"}, read_finish, 1);
  endtask

  task automatic release_start(input string tag);
    start_flag = 1'b0;
    read_req   = 1'b0;
    repeat (3) @(negedge system_clk);
    check({tag, "_idle_state"}, dut.state, 0);  // IDLE is encoded as zero
    check({tag, "_idle_finish"}, read_finish, 0);
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (rxb.size() < target && n < 2000) begin
      @(negedge system_clk);
      n++;
    end
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [31:0] sa,
                             input int n);
    logic [31:0] got;
    check({tag, "_nbytes"}, rxb.size() - base, n);
    for (int i = 0; i < n; i++) begin
      got = (base + i < rxb.size()) ? {24'h0, rxb[base + i]} : 32'hFFFF_FFFF;
      check($sformatf("%s_d%0d", tag, i), got, {24'h0, fdata(sa + i)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w0, b0, s0, sw0, n1;

    // Reset values
    repeat (3) @(negedge system_clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_dv", data_valid, 0);
    check("rst_finish", read_finish, 0);
    check("rst_dout", data_out, 0);
    check("rst_sw", dut.sw, 0);
    check("rst_state", dut.state, 0);
    check("rst_addr", dut.cur_addr_q, 0);
    system_reset_n = 1'b0;
    repeat (2) @(negedge system_clk);

    // T1: normal read 0x00..0x10 started by start_flag
    w0 = win_cnt; b0 = rxb.size(); s0 = stall_cnt;
    do_read(32'h0, 32'h10, 2'b00, 1'b0);
    wait_finish("t1");
    repeat (4) @(negedge system_clk);
    check("t1_finish_hold", read_finish, 1);
    release_start("t1");
    check("t1_windows", win_cnt - w0, 2);
    check("t1_die_nb", win_nb[w0], 2);
    check("t1_die_b0", win_b[w0][0], 8'hC2);
    check("t1_die_b1", win_b[w0][1], 8'h00);
    check("t1_cmd", win_b[w0 + 1][0], 8'h13);
    for (int k = 1; k < 5; k++) check($sformatf("t1_addr%0d", k), win_b[w0 + 1][k], 8'h00);
    check("t1_no_stall", stall_cnt - s0, 0);
    check_bytes("t1", b0, 32'h0, 17);

    // T2: back-pressure mid-byte, plus stray starts while busy
    w0 = win_cnt; b0 = rxb.size(); s0 = stall_cnt;
    do_read(32'h1000, 32'h100F, 2'b00, 1'b1);
    wait_bytes(b0 + 5);
    repeat (6) @(negedge system_clk);
    fifo_full  = 1'b1;
    start_flag = 1'b1;
    read_req   = 1'b1;
    @(negedge system_clk);
    read_req   = 1'b0;
    @(negedge system_clk);
    fifo_full  = 1'b0;
    start_flag = 1'b0;
    wait_finish("t2");
    release_start("t2");
    check("t2_windows", win_cnt - w0, 2);
    check("t2_stalled", (stall_cnt - s0) > 0, 1);
    check_bytes("t2", b0, 32'h1000, 16);

    // T3: crossing the die boundary at 0x02000000
    w0 = win_cnt; b0 = rxb.size(); sw0 = sw_cnt;
    do_read(32'h01FF_FFF0, 32'h0200_0010, 2'b00, 1'b0);
    wait_finish("t3");
    release_start("t3");
    check("t3_windows", win_cnt - w0, 4);
    check("t3_die0", win_b[w0][1], 8'h00);
    check("t3_a1", win_b[w0 + 1][1], 8'h01);
    check("t3_a2", win_b[w0 + 1][2], 8'hFF);
    check("t3_a3", win_b[w0 + 1][3], 8'hFF);
    check("t3_a4", win_b[w0 + 1][4], 8'hF0);
    check("t3_die1_b0", win_b[w0 + 2][0], 8'hC2);
    check("t3_die1_b1", win_b[w0 + 2][1], 8'h01);
    check("t3_die1_nb", win_nb[w0 + 2], 2);
    check("t3_cmd2", win_b[w0 + 3][0], 8'h13);
    check("t3_b1", win_b[w0 + 3][1], 8'h02);
    check("t3_b2", win_b[w0 + 3][2], 8'h00);
    check("t3_b3", win_b[w0 + 3][3], 8'h00);
    check("t3_b4", win_b[w0 + 3][4], 8'h00);
    check("t3_sw_cycles", sw_cnt - sw0, 1);
    check_bytes("t3", b0, 32'h01FF_FFF0, 33);

    // T4: fast read with dummy clocks
    w0 = win_cnt; b0 = rxb.size();
    do_read(32'h0, 32'h3, 2'b01, 1'b1);
    wait_finish("t4");
    release_start("t4");
    check("t4_windows", win_cnt - w0, 2);
    check("t4_cmd", win_b[w0 + 1][0], 8'h0C);
    check("t4_die_clks", win_clk[w0], 16);
    check("t4_read_clks", win_clk[w0 + 1], 80);
    check_bytes("t4", b0, 32'h0, 4);

    // T5: empty range goes straight to FINISH
    w0 = win_cnt; b0 = rxb.size();
    do_read(32'h100, 32'hFF, 2'b00, 1'b0);
    wait_finish("t5");
    release_start("t5");
    check("t5_no_cs", win_cnt - w0, 0);
    check("t5_no_data", rxb.size() - b0, 0);

    // T6: reset in the middle of DATA
    b0 = rxb.size();
    do_read(32'h0, 32'hFF, 2'b00, 1'b1);
    wait_bytes(b0 + 3);
    check("t6_reached_data", dut.state, 5);  // DATA
    system_reset_n = 1'b1;
    @(negedge system_clk);
    check("t6_cs_n", spi_cs_n, 1);
    check("t6_state", dut.state, 0);
    check("t6_sclk", spi_sclk, 0);
    check("t6_dv", data_valid, 0);
    n1 = rxb.size();
    repeat (3) @(negedge system_clk);
    system_reset_n = 1'b0;
    repeat (5) @(negedge system_clk);
    check("t6_no_dv_after", rxb.size() - n1, 0);
    check("t6_stay_idle", dut.state, 0);
    check("t6_cs_idle", spi_cs_n, 1);

    check("cs_gap_min4", min_gap >= 4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_read.md
SPI_FLASH_READ -- requirements
Module: spi_flash_read

Interface
REQ-001 The block SHALL have these ports:
- system_clk  in  1  sole clock; all logic on rising edge.
- system_reset_n  in  1  synchronous, active-high reset; asserted when high despite the legacy suffix.
- start_flag  in  1  level request; a rising edge in IDLE starts a read.
- read_req  in  1  one-cycle start pulse; equivalent to a start_flag rising edge.
- start_addr  in  32  first byte address, sampled at start.
- end_addr  in  32  last byte address (inclusive), sampled at start.
- mode  in  2  00 = normal read; 01 = fast read; 10/11 behave as 00.
- fifo_full  in  1  downstream back-pressure.
- spi_miso  in  1  flash serial data out.
- spi_cs_n  out  1  flash chip select, active low.
- spi_sclk  out  1  SPI mode-0 clock.
- spi_mosi  out  1  flash serial data in.
- data_out  out  8  received byte.
- data_valid  out  1  one-cycle strobe qualifying data_out.
- read_finish  out  1  transaction-complete level.

Function
REQ-002 spi_sclk SHALL be system_clk/2 and idle low; spi_mosi SHALL change on the sclk falling edge; spi_miso SHALL be sampled on the sclk rising edge; all transfers SHALL be MSB first.
REQ-003 The FSM registers SHALL be named state and next_state, with states IDLE, DIE_SEL, CMD, ADDR, DUMMY, DATA, PAUSE, CS_GAP and FINISH.
REQ-004 On a start in IDLE, the block SHALL latch the addresses, set cur_addr = start_addr and remaining = end_addr - start_addr + 1 (32-bit), and go to DIE_SEL.
REQ-005 If end_addr < start_addr, the block SHALL go directly to FINISH without asserting spi_cs_n.
REQ-006 DIE_SEL SHALL send the 2-byte sequence 0xC2 followed by 0x00 or 0x01 (die = cur_addr[25]) with spi_cs_n low, then pass through CS_GAP.
REQ-007 CS_GAP SHALL hold spi_cs_n high for at least 4 system_clk cycles.
REQ-008 CMD SHALL send 0x13 for mode 00, 10 or 11, and 0x0C for mode 01; ADDR SHALL then send the 4 bytes of cur_addr.
REQ-009 DUMMY SHALL add 8 sclk cycles in mode 01 only and is skipped in other modes.
REQ-010 In DATA, data_out SHALL update and data_valid SHALL pulse for one system_clk cycle within 2 system_clk cycles after the 8th sampled bit of each byte; cur_addr SHALL then increment and remaining SHALL decrement.
REQ-011 If fifo_full is high at a byte boundary, the FSM SHALL enter PAUSE: spi_sclk held low, spi_cs_n held low, no data_valid.
REQ-012 PAUSE SHALL resume DATA on the first cycle fifo_full is low; a byte already in progress SHALL always complete first.
REQ-013 When cur_addr rolls over from 0x01FFFFFF to 0x02000000 and remaining > 0, the block SHALL raise spi_cs_n, pulse internal signal sw high for exactly one system_clk cycle, then go CS_GAP -> DIE_SEL(die 1) -> CS_GAP -> CMD and continue from 0x02000000.
REQ-014 When remaining reaches 0, the block SHALL raise spi_cs_n and enter FINISH.
REQ-015 In FINISH, read_finish SHALL stay high until start_flag is low and read_req is low, then the FSM SHALL return to IDLE.
REQ-016 start_flag edges and read_req pulses outside IDLE SHALL be ignored.
REQ-017 Every state transition SHALL take effect on a system_clk rising edge; each state encoding SHALL be a distinct value.

Reset
REQ-018 While system_reset_n is high at a clock edge:
- state SHALL be IDLE.
- spi_cs_n SHALL be 1; spi_sclk, spi_mosi, data_valid, read_finish and sw SHALL be 0.
- data_out and the address/count registers SHALL be 0.
REQ-019 Reset asserted mid-transaction SHALL abort within one cycle with outputs at reset values; no data_valid SHALL be produced after the reset edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then start 0x00000000..0x00000010, mode 00 -> C2 00, CS gap, 13 00 00 00 00, 17 data_valid pulses, read_finish high, IDLE after start_flag drops.
- Start 0x00001000..0x0000100F with fifo_full high 2 cycles mid-byte -> that byte completes, sclk stalls during PAUSE, exactly 16 bytes, data order preserved.
- Start 0x01FFFFF0..0x02000010 -> 16 bytes, sw one pulse, C2 01, 13 02 00 00 00, 17 more bytes, 33 total.
- Mode 01, 0x00000000..0x00000003 -> opcode 0C, 8 dummy clocks, 4 bytes.
- end_addr < start_addr -> read_finish with spi_cs_n never low.
- Reset mid-DATA -> spi_cs_n = 1 and state = IDLE the next cycle.
